battleship_game_ctrl: RTL

- Top-level game sequencer for the two-player battleship VGA design.
- Enables each player's ship-placement counter in turn, then alternates attack turns.
- Issues attack requests to the board-lookup datapath over a req/ack handshake and tallies hits.
- Declares the winner; exposes its state for the VGA overlay.

---
 rtl/battleship_game_ctrl.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/battleship_game_ctrl.sv
// -----------------------------------------------------------------------------
// battleship_game_ctrl
// Top-level game sequencer for the two-player battleship VGA design.
// Runs ship placement for each player in turn, then alternates attack turns.
// Attacks go to the board-lookup datapath over a req/ack handshake, and the
// controller counts hits until one player reaches HIT_TARGET.
//
// Optional build macro: TURN_TIMEOUT_EN
//   Adds a per-turn timer. A turn is forfeited after TIMEOUT_CYCLES idle
//   cycles in TURN. When the macro is not defined, turn_timeout is tied to 0.
//
// Ports:
//   clk, rst                 clock and asynchronous active-high reset
//   start                    single-cycle start/restart pulse (IDLE/OVER only)
//   p1/p2_finished_placing   placement counters reached their ship count
//   fire_n                   raw active-low fire switch, asynchronous to clk
//   p1/p2_placing            placement counter enables (registered)
//   attack_req/attack_player attack request and attacker id to board lookup
//   attack_ack/attack_hit    lookup done pulse and its hit result
//   p1_hits/p2_hits          hit tallies
//   active_player            player whose turn it is
//   game_over/winner         end-of-game flag and winning player
//   state_o                  encoded FSM state for the VGA overlay
//   turn_timeout             one-cycle pulse when a turn is forfeited
// -----------------------------------------------------------------------------
module battleship_game_ctrl #(
    parameter int HIT_TARGET     = 17,
    parameter int HIT_W          = 5,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             p1_finished_placing,
    input  logic             p2_finished_placing,
    input  logic             fire_n,
    output logic             p1_placing,
    output logic             p2_placing,
    output logic             attack_req,
    output logic             attack_player,
    input  logic             attack_ack,
    input  logic             attack_hit,
    output logic [HIT_W-1:0] p1_hits,
    output logic [HIT_W-1:0] p2_hits,
    output logic             active_player,
    output logic             game_over,
    output logic             winner,
    output logic [2:0]       state_o,
    output logic             turn_timeout
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PLACE1 = 3'd1,
        ST_PLACE2 = 3'd2,
        ST_TURN   = 3'd3,
        ST_ATTACK = 3'd4,
        ST_OVER   = 3'd5
    } state_t;

    localparam logic [HIT_W-1:0] HIT_MAX = HIT_W'(HIT_TARGET);

    state_t           state;
    logic             fire_sync1;
    logic             fire_sync2;
    logic             fire_sync3;
    logic             fire_event;
    logic [HIT_W-1:0] attacker_next;

`ifdef TURN_TIMEOUT_EN
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] turn_timer;
`endif

    // Saturating increment of a hit counter; never exceeds HIT_TARGET.
    function automatic logic [HIT_W-1:0] sat_inc(input logic [HIT_W-1:0] value);
        if (value >= HIT_MAX) begin
            return HIT_MAX;
        end else begin
            return value + HIT_W'(1);
        end
    endfunction

    // Two-flop synchroniser plus a history flop for falling-edge detection.
    // The flops clear to 0 so that a switch held low through reset cannot
    // produce a spurious event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fire_sync1 <= 1'b0;
            fire_sync2 <= 1'b0;
            fire_sync3 <= 1'b0;
        end else begin
            fire_sync1 <= fire_n;
            fire_sync2 <= fire_sync1;
            fire_sync3 <= fire_sync2;
        end
    end

    // A high-to-low transition of the synchronised switch.
    assign fire_event = fire_sync3 & ~fire_sync2;

    // Attacker's hit count after a hit, used for both the update and the win test.
    always_comb begin
        if (attack_player) begin
            attacker_next = sat_inc(p2_hits);
        end else begin
            attacker_next = sat_inc(p1_hits);
        end
    end

    // Game sequencer with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            p1_placing    <= 1'b0;
            p2_placing    <= 1'b0;
            attack_req    <= 1'b0;
            attack_player <= 1'b0;
            p1_hits       <= '0;
            p2_hits       <= '0;
            active_player <= 1'b0;
            game_over     <= 1'b0;
            winner        <= 1'b0;
            turn_timeout  <= 1'b0;
`ifdef TURN_TIMEOUT_EN
            turn_timer    <= 32'd0;
`endif
        end else begin
            turn_timeout <= 1'b0;
            case (state)
                ST_IDLE, ST_OVER: begin
                    // The counters and the winner stay frozen in OVER until a restart.
                    if (start) begin
                        state         <= ST_PLACE1;
                        p1_placing    <= 1'b1;
                        p1_hits       <= '0;
                        p2_hits       <= '0;
                        active_player <= 1'b0;
                        game_over     <= 1'b0;
                        winner        <= 1'b0;
                    end
                end
                ST_PLACE1: begin
                    if (p1_finished_placing) begin
                        state      <= ST_PLACE2;
                        p1_placing <= 1'b0;
                        p2_placing <= 1'b1;
                    end
                end
                ST_PLACE2: begin
                    if (p2_finished_placing) begin
                        state         <= ST_TURN;
                        p2_placing    <= 1'b0;
                        active_player <= 1'b0;
`ifdef TURN_TIMEOUT_EN
                        turn_timer    <= 32'd0;
`endif
                    end
                end
                ST_TURN: begin
                    // On the expiry cycle a fire event takes priority over the forfeit.
                    if (fire_event) begin
                        state         <= ST_ATTACK;
                        attack_req    <= 1'b1;
                        attack_player <= active_player;
                    end
`ifdef TURN_TIMEOUT_EN
                    else if (turn_timer == TIMEOUT_LAST) begin
                        active_player <= ~active_player;
                        turn_timer    <= 32'd0;
                        turn_timeout  <= 1'b1;
                    end else begin
                        turn_timer <= turn_timer + 32'd1;
                    end
`endif
                end
                ST_ATTACK: begin
                    if (attack_ack) begin
                        attack_req <= 1'b0;
                        if (attack_hit) begin
                            if (attack_player) begin
                                p2_hits <= attacker_next;
                            end else begin
                                p1_hits <= attacker_next;
                            end
                        end
                        if (attack_hit && (attacker_next == HIT_MAX)) begin
                            state     <= ST_OVER;
                            game_over <= 1'b1;
                            winner    <= attack_player;
                        end else begin
                            state         <= ST_TURN;
                            active_player <= ~active_player;
`ifdef TURN_TIMEOUT_EN
                            turn_timer    <= 32'd0;
`endif
                        end
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    p1_placing <= 1'b0;
                    p2_placing <= 1'b0;
                    attack_req <= 1'b0;
                    game_over  <= 1'b0;
                end
            endcase
        end
    end

    assign state_o = state;

endmodule
